cell_plotter: RTL and testbench

//   Consumer side of the game controller's plot/s_color request. On a one-cycle

---
 rtl/maze_pkg.sv | 27 ++
 rtl/cell_scan_counter.sv | 47 ++++
 rtl/cell_plotter.sv | 142 ++++++++++++++
 tb/tb_cell_plotter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared constants and types for the maze display path.
//   - Default cell geometry and visible screen size.
//   - Foreground (player) and background (erase) colours.
//   - State encoding for the cell_plotter FSM.
//   - cnt_width(): counter width needed to count 0..n-1, at least 1 bit.
package maze_pkg;

  localparam int DEF_CELL_W   = 4;
  localparam int DEF_CELL_H   = 4;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int DEF_COLOR_W  = 3;

  localparam logic [DEF_COLOR_W-1:0] MAZE_FG = 3'b010;
  localparam logic [DEF_COLOR_W-1:0] MAZE_BG = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } plot_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cell_scan_counter.sv
// Two-dimensional raster counter for one maze cell.
//   clk, reset : clock, synchronous active-high reset
//   clear      : force col/row back to 0 (held while the plotter is idle)
//   en         : advance one pixel; col is the inner counter, row the outer
//   col, row   : current pixel offset inside the cell
//   last       : current pixel is the bottom-right one of the cell
module cell_scan_counter
  import maze_pkg::*;
#(
  parameter int CELL_W = DEF_CELL_W,
  parameter int CELL_H = DEF_CELL_H,
  parameter int CW     = cnt_width(CELL_W),
  parameter int RW     = cnt_width(CELL_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  localparam logic [CW-1:0] LAST_COL = CW'(CELL_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(CELL_H - 1);

  logic col_wrap;
  assign col_wrap = (col == LAST_COL);
  assign last     = col_wrap && (row == LAST_ROW);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col_wrap) begin
        col <= '0;
        row <= (row == LAST_ROW) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cell_plotter.sv
// Rasterises one maze cell into the VGA adapter's pixel-write port, one pixel
// per clock, on a single-cycle plot request from the game controller.
//   clk, reset     : clock, synchronous active-high reset
//   plot           : draw request, taken only while ready=1
//   s_color        : 0 = background (erase), 1 = player; latched with plot
//   cell_x, cell_y : cell column/row, latched with plot
//   ready          : combinational, high only in IDLE
//   busy           : registered, high in DRAW and DONE
//   done           : registered one-cycle pulse after the last pixel
//   vga_x, vga_y, vga_colour, vga_plot : registered pixel-write port
// Build option: define CELL_PLOTTER_CLIP_EN to suppress vga_plot for pixels
// outside SCREEN_W x SCREEN_H (scan timing is unchanged).
module cell_plotter
  import maze_pkg::*;
#(
  parameter int CELL_W   = DEF_CELL_W,
  parameter int CELL_H   = DEF_CELL_H,
  parameter int GX_W     = 5,
  parameter int GY_W     = 5,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter logic [COLOR_W-1:0] FG_COLOR = COLOR_W'(MAZE_FG),
  parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(MAZE_BG),
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               plot,
  input  logic               s_color,
  input  logic [GX_W-1:0]    cell_x,
  input  logic [GY_W-1:0]    cell_y,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_colour,
  output logic               vga_plot
);

  localparam int CW = cnt_width(CELL_W);
  localparam int RW = cnt_width(CELL_H);

  plot_state_t        state;
  logic [X_W-1:0]     base_x;
  logic [Y_W-1:0]     base_y;
  logic [COLOR_W-1:0] colour_q;
  logic               last_sent;   // final pixel has been issued
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic               scan_last;
  logic [X_W-1:0]     px;
  logic [Y_W-1:0]     py;
  logic               in_screen;

  // NOTE: ready is decoded straight from the state register so the
  // controller sees it in the same cycle; it adds no extra latency.
  assign ready = (state == ST_IDLE);

  cell_scan_counter #(
    .CELL_W (CELL_W),
    .CELL_H (CELL_H),
    .CW     (CW),
    .RW     (RW)
  ) u_scan (
    .clk   (clk),
    .reset (reset),
    .clear (state == ST_IDLE),
    .en    ((state == ST_DRAW) && !last_sent),
    .col   (col),
    .row   (row),
    .last  (scan_last)
  );

  // Coordinates wrap modulo 2^X_W / 2^Y_W by construction.
  assign px = base_x + X_W'(col);
  assign py = base_y + Y_W'(row);

`ifdef CELL_PLOTTER_CLIP_EN
  assign in_screen = (32'(px) < SCREEN_W) && (32'(py) < SCREEN_H);
`else
  assign in_screen = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      base_x     <= '0;
      base_y     <= '0;
      colour_q   <= '0;
      last_sent  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done     <= 1'b0;
          vga_plot <= 1'b0;
          if (plot) begin
            base_x    <= X_W'(32'(cell_x) * 32'(CELL_W));
            base_y    <= Y_W'(32'(cell_y) * 32'(CELL_H));
            colour_q  <= s_color ? FG_COLOR : BG_COLOR;
            last_sent <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (last_sent) begin
            vga_plot <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else begin
            vga_x      <= px;
            vga_y      <= py;
            vga_colour <= colour_q;
            vga_plot   <= in_screen;
            last_sent  <= scan_last;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy     <= 1'b0;
          done     <= 1'b0;
          vga_plot <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cell_plotter.sv
// Directed self-checking bench for cell_plotter. A default 4x4 instance covers
// drawing, request handling, reset abort and the edge-of-screen cell; a 1x1
// instance covers the degenerate cell size.
module tb_cell_plotter;

  logic clk = 1'b0;
  logic reset;

  // Default 4x4 instance
  logic       plot, s_color;
  logic [4:0] cell_x, cell_y;
  logic       ready, busy, done, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  // 1x1 instance
  logic       p1_plot, p1_s_color;
  logic [4:0] p1_cell_x, p1_cell_y;
  logic       p1_ready, p1_busy, p1_done, p1_vga_plot;
  logic [7:0] p1_vga_x;
  logic [6:0] p1_vga_y;
  logic [2:0] p1_vga_colour;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cell_plotter dut (
    .clk(clk), .reset(reset), .plot(plot), .s_color(s_color),
    .cell_x(cell_x), .cell_y(cell_y), .ready(ready), .busy(busy), .done(done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  cell_plotter #(.CELL_W(1), .CELL_H(1)) dut1 (
    .clk(clk), .reset(reset), .plot(p1_plot), .s_color(p1_s_color),
    .cell_x(p1_cell_x), .cell_y(p1_cell_y), .ready(p1_ready), .busy(p1_busy),
    .done(p1_done), .vga_x(p1_vga_x), .vga_y(p1_vga_y),
    .vga_colour(p1_vga_colour), .vga_plot(p1_vga_plot)
  );

  // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    plot = 1'b0; s_color = 1'b0; cell_x = '0; cell_y = '0;
    p1_plot = 1'b0; p1_s_color = 1'b0; p1_cell_x = '0; p1_cell_y = '0;
    repeat (3) tick();
    checks++;
    if ({ready, busy, done, vga_plot, vga_x, vga_y, vga_colour} !== {4'b1000, 18'd0}) begin
      errors++;
      $display("FAIL reset_state: got r/b/d/p=%b%b%b%b x=%0d y=%0d c=%0d, expected 1000 0 0 0",
               ready, busy, done, vga_plot, vga_x, vga_y, vga_colour);
    end
    checks++;
    if ({p1_ready, p1_busy, p1_done, p1_vga_plot} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_state_1x1: got r/b/d/p=%b%b%b%b, expected 1000",
               p1_ready, p1_busy, p1_done, p1_vga_plot);
    end
    reset = 1'b0;
    tick();
  endtask

  // One full 4x4 draw with its expected base coordinate and colour.
  task automatic test_draw(input string name, input logic [4:0] cx, input logic [4:0] cy,
                           input logic sc, input logic [7:0] bx, input logic [6:0] by,
                           input logic [2:0] col);
    logic [7:0] ex;
    logic [6:0] ey;
    cell_x = cx; cell_y = cy; s_color = sc; plot = 1'b1;
    tick();
    plot = 1'b0;
    checks++;
    if ({ready, busy, vga_plot} !== 3'b010) begin
      errors++;
      $display("FAIL %s_accept: got ready/busy/plot=%b%b%b, expected 010", name, ready, busy, vga_plot);
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      ex = bx + 8'(k % 4);
      ey = by + 7'(k / 4);
      checks++;
      if ({vga_plot, vga_x, vga_y, vga_colour, busy} !== {1'b1, ex, ey, col, 1'b1}) begin
        errors++;
        $display("FAIL %s_pixel%0d: got plot=%b x=%0d y=%0d c=%b busy=%b, expected plot=1 x=%0d y=%0d c=%b busy=1",
                 name, k, vga_plot, vga_x, vga_y, vga_colour, busy, ex, ey, col);
      end
    end
    tick();
    checks++;
    if ({done, vga_plot, busy, ready, vga_x, vga_y} !== {4'b1010, bx + 8'd3, by + 7'd3}) begin
      errors++;
      $display("FAIL %s_done: got d/p/b/r=%b%b%b%b x=%0d y=%0d, expected 1010 x=%0d y=%0d",
               name, done, vga_plot, busy, ready, vga_x, vga_y, bx + 8'd3, by + 7'd3);
    end
    tick();
    checks++;
    if ({done, vga_plot, busy, ready} !== 4'b0001) begin
      errors++;
      $display("FAIL %s_idle: got d/p/b/r=%b%b%b%b, expected 0001", name, done, vga_plot, busy, ready);
    end
  endtask

  // plot held high for 30 cycles: one draw, then a second accept once ready returns.
  task automatic test_back_to_back;
    int accepts = 0, plots = 0, dones = 0, gap = 0, low_run = 0;
    cell_x = 5'd1; cell_y = 5'd1; s_color = 1'b1; plot = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (ready) begin
        accepts++;
        if (accepts == 2) gap = low_run;
      end else begin
        low_run++;
      end
      tick();
      if (vga_plot) plots++;
      if (done) dones++;
    end
    plot = 1'b0;
    for (int i = 0; i < 40 && !ready; i++) begin
      tick();
      if (vga_plot) plots++;
      if (done) dones++;
    end
    checks++;
    if (accepts !== 2) begin
      errors++;
      $display("FAIL hold_accepts: got %0d accepts, expected 2", accepts);
    end
    checks++;
    if (gap !== 18) begin
      errors++;
      $display("FAIL hold_ready_gap: got %0d not-ready cycles, expected 18", gap);
    end
    checks++;
    if ({plots, dones, ready} !== {32'd32, 32'd2, 1'b1}) begin
      errors++;
      $display("FAIL hold_totals: got plots=%0d dones=%0d ready=%b, expected 32 2 1", plots, dones, ready);
    end
  endtask

  // Reset asserted while pixel 7 is on the port aborts the draw.
  task automatic test_reset_abort;
    int dones = 0;
    cell_x = 5'd2; cell_y = 5'd2; s_color = 1'b1; plot = 1'b1;
    tick();
    plot = 1'b0;
    repeat (8) tick();
    checks++;
    if ({vga_plot, vga_x, vga_y} !== {1'b1, 8'd11, 7'd9}) begin
      errors++;
      $display("FAIL abort_pixel7: got plot=%b x=%0d y=%0d, expected 1 11 9", vga_plot, vga_x, vga_y);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({vga_plot, busy, done, ready, vga_x, vga_y} !== {4'b0001, 15'd0}) begin
      errors++;
      $display("FAIL abort_next: got p/b/d/r=%b%b%b%b x=%0d y=%0d, expected 0001 0 0",
               vga_plot, busy, done, ready, vga_x, vga_y);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || vga_plot || !ready) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d active cycles after abort, expected 0", dones);
    end
  endtask

  // Cell (31,31) lies at x=124..127, y=124..127: below the screen height.
  task automatic test_edge_cell;
    int plots = 0, dones = 0, low = 0, bad = 0, k = 0, exp_plots;
`ifdef CELL_PLOTTER_CLIP_EN
    exp_plots = 0;
`else
    exp_plots = 16;
`endif
    cell_x = 5'd31; cell_y = 5'd31; s_color = 1'b1; plot = 1'b1;
    tick();
    plot = 1'b0;
    for (int i = 0; i < 40 && !ready; i++) begin
      low++;
      if (busy !== 1'b1) bad++;
      if (vga_plot) begin
        if ({vga_x, vga_y} !== {8'd124 + 8'(k % 4), 7'd124 + 7'(k / 4)}) bad++;
        plots++;
        k++;
      end
      if (done) dones++;
      tick();
    end
    checks++;
    if (plots !== exp_plots) begin
      errors++;
      $display("FAIL edge_plots: got %0d, expected %0d", plots, exp_plots);
    end
    checks++;
    if ({dones, low, bad} !== {32'd1, 32'd18, 32'd0}) begin
      errors++;
      $display("FAIL edge_timing: got dones=%0d busy_cycles=%0d bad=%0d, expected 1 18 0", dones, low, bad);
    end
  endtask

  // 1x1 cell: one plot cycle at the cell index itself, then done.
  task automatic test_single_pixel;
    p1_cell_x = 5'd5; p1_cell_y = 5'd6; p1_s_color = 1'b1; p1_plot = 1'b1;
    tick();
    p1_plot = 1'b0;
    checks++;
    if ({p1_ready, p1_busy, p1_vga_plot} !== 3'b010) begin
      errors++;
      $display("FAIL one_accept: got r/b/p=%b%b%b, expected 010", p1_ready, p1_busy, p1_vga_plot);
    end
    tick();
    checks++;
    if ({p1_vga_plot, p1_vga_x, p1_vga_y, p1_vga_colour} !== {1'b1, 8'd5, 7'd6, 3'b010}) begin
      errors++;
      $display("FAIL one_pixel: got plot=%b x=%0d y=%0d c=%b, expected 1 5 6 010",
               p1_vga_plot, p1_vga_x, p1_vga_y, p1_vga_colour);
    end
    tick();
    checks++;
    if ({p1_done, p1_vga_plot, p1_busy, p1_ready} !== 4'b1010) begin
      errors++;
      $display("FAIL one_done: got d/p/b/r=%b%b%b%b, expected 1010", p1_done, p1_vga_plot, p1_busy, p1_ready);
    end
    tick();
    checks++;
    if ({p1_done, p1_busy, p1_ready} !== 3'b001) begin
      errors++;
      $display("FAIL one_idle: got d/b/r=%b%b%b, expected 001", p1_done, p1_busy, p1_ready);
    end
  endtask

  initial begin
    test_reset();
    test_draw("player", 5'd2, 5'd3, 1'b1, 8'd8, 7'd12, 3'b010);
    test_draw("erase", 5'd0, 5'd0, 1'b0, 8'd0, 7'd0, 3'b000);
    test_back_to_back();
    test_reset_abort();
    test_edge_cell();
    test_single_pixel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
